// File: rtl/handshake_rx_pkg.sv
// Shared definitions for the 4-phase handshake receiver: FSM state encoding
// and default parameter values.
package handshake_rx_pkg;

    localparam int DEF_DATA_WIDTH    = 8;
    localparam int DEF_SETTLE_CYCLES = 2;

    // state      | meaning
    // RESYNC     | after reset; wait for request low so a stale request is never delivered
    // IDLE       | no transfer in progress; a request starts one
    // SETTLE     | request seen; let the quasi-static bus settle before sampling it
    // DELIVER    | captured word presented to the local consumer
    // ACK        | acknowledge raised; wait for the source to drop its request
    typedef enum logic [2:0] {
        ST_RESYNC  = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DELIVER = 3'd3,
        ST_ACK     = 3'd4
    } rx_state_e;

endpackage : handshake_rx_pkg

// File: rtl/handshake_receiver.sv
// Destination side of a 4-phase req/ack clock-domain crossing. The request
// arrives already synchronized; the data bus is sampled after a settle delay,
// handed to a local consumer, then acknowledged back to the source.
module handshake_receiver
    import handshake_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_sync,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_ack,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_err,
    output logic [7:0]            o_xfer_cnt
);

    // Counter must be able to hold SETTLE_CYCLES itself for the width rule.
    localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [7:0]            xfer_cnt_q, xfer_cnt_d;

    // Next-state and next-output decode for the handshake sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = ack_q;
        valid_d    = valid_q;
        data_d     = data_q;
        err_d      = 1'b0;
        xfer_cnt_d = xfer_cnt_q;

        unique case (state_q)
            ST_RESYNC: begin
                ack_d = 1'b0;
                if (!i_req_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_req_sync) begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (!i_req_sync) begin
                    // Source withdrew before the bus was sampled: flag it,
                    // keep whatever word was previously captured.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        data_d  = i_data;
                        valid_d = 1'b1;
                        state_d = ST_DELIVER;
                    end
                end
            end
            ST_DELIVER: begin
                // Request is protocol-bound high here, so it is not examined.
                if (i_ready) begin
                    valid_d    = 1'b0;
                    ack_d      = 1'b1;
                    xfer_cnt_d = xfer_cnt_q + 8'd1;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!i_req_sync) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RESYNC;
                ack_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any in-flight handshake.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RESYNC;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
            xfer_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign o_ack      = ack_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_err      = err_q;
    assign o_xfer_cnt = xfer_cnt_q;

endmodule : handshake_receiver

// File: tb/tb_handshake_receiver.sv
// Bench for handshake_receiver: a cycle-level protocol model checked against
// the DUT on every falling edge, plus directed scenarios with literal checks.
module tb_handshake_receiver;

    localparam int DW = 8;
    localparam int SC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ready = 1'b0;
    logic          ack;
    logic          valid;
    logic [DW-1:0] odata;
    logic          err;
    logic [7:0]    xcnt;

    int compared = 0;
    int mismatched = 0;

    handshake_receiver #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req_sync (req),
        .i_data     (data),
        .i_ready    (ready),
        .o_ack      (ack),
        .o_valid    (valid),
        .o_data     (odata),
        .o_err      (err),
        .o_xfer_cnt (xcnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Protocol model. Phases: waiting for low after reset, idle, settling
    // (word sampled SC edges after the request is seen), holding the word
    // for the consumer, acknowledged and waiting for the request to drop.
    typedef enum int {P_WAITLOW, P_IDLE, P_SETTLING, P_HOLDING, P_ACKED} phase_t;
    phase_t     m_phase;
    longint     cyc = 0;
    longint     m_seen_cyc;
    bit         m_ack, m_valid, m_err;
    logic [7:0] m_data;
    int         m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_WAITLOW;
            m_ack = 0; m_valid = 0; m_err = 0; m_data = '0; m_cnt = 0;
        end else begin
            cyc++;
            m_err = 0;
            case (m_phase)
                P_WAITLOW: if (!req) m_phase = P_IDLE;
                P_IDLE: if (req) begin
                    m_phase    = P_SETTLING;
                    m_seen_cyc = cyc;
                end
                P_SETTLING: begin
                    if (!req) begin
                        m_phase = P_IDLE;
                        m_err   = 1;
                    end else if (cyc - m_seen_cyc == SC) begin
                        m_data  = data;
                        m_valid = 1;
                        m_phase = P_HOLDING;
                    end
                end
                P_HOLDING: if (ready) begin
                    m_valid = 0;
                    m_ack   = 1;
                    m_cnt   = (m_cnt + 1) % 256;
                    m_phase = P_ACKED;
                end
                P_ACKED: if (!req) begin
                    m_ack   = 0;
                    m_phase = P_IDLE;
                end
                default: m_phase = P_WAITLOW;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("model_ack",   int'(ack),   int'(m_ack));
            check("model_valid", int'(valid), int'(m_valid));
            check("model_err",   int'(err),   int'(m_err));
            check("model_cnt",   int'(xcnt),  m_cnt);
            if (m_valid) check("model_data", int'(odata), int'(m_data));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_ack(input bit level, input string name);
        int n = 0;
        while (ack !== level && n < 20) begin
            tick();
            n++;
        end
        if (ack !== level) check(name, int'(ack), int'(level));
    endtask

    // One complete transfer with the consumer always ready.
    task automatic do_xfer(input logic [7:0] d);
        data  = d;
        ready = 1'b1;
        req   = 1'b1;
        wait_ack(1'b1, "xfer_ack_rise_timeout");
        req = 1'b0;
        wait_ack(1'b0, "xfer_ack_fall_timeout");
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        req = 1'b0; ready = 1'b0; data = '0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_ack",   int'(ack),   0);
        check("rst_valid", int'(valid), 0);
        check("rst_data",  int'(odata), 0);
        check("rst_err",   int'(err),   0);
        check("rst_cnt",   int'(xcnt),  0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Basic transfer, consumer ready: valid after SC edges, ack next edge
        data = 8'hA5; ready = 1'b1; req = 1'b1;
        tick();                                   // entered SETTLE
        tick();
        check("b_valid_early", int'(valid), 0);
        tick();
        check("b_valid_rise", int'(valid), 1);
        check("b_data",       int'(odata), 8'hA5);
        check("b_ack_low",    int'(ack),   0);
        tick();
        check("b_ack_rise",   int'(ack),   1);
        check("b_valid_fall", int'(valid), 0);
        check("b_cnt1",       int'(xcnt),  1);
        req = 1'b0;
        tick();
        check("b_ack_fall",   int'(ack),   0);
        check("b_cnt_hold",   int'(xcnt),  1);

        // Consumer stalls for 10 cycles in DELIVER
        ready = 1'b0; data = 8'hA5; req = 1'b1;
        tick(); tick(); tick();
        check("s_valid", int'(valid), 1);
        data = 8'h3C;                             // bus moving must not disturb held word
        for (int i = 0; i < 10; i++) begin
            tick();
            check("s_hold_valid", int'(valid), 1);
            check("s_hold_data",  int'(odata), 8'hA5);
            check("s_hold_ack",   int'(ack),   0);
        end
        ready = 1'b1;
        tick();
        check("s_ack",   int'(ack),   1);
        check("s_valid0", int'(valid), 0);
        check("s_cnt2",  int'(xcnt),  2);
        req = 1'b0;
        tick();
        check("s_ack_fall", int'(ack), 0);

        // One-cycle request glitch aborts the settle
        req = 1'b1;
        tick();                                   // entered SETTLE
        req = 1'b0;
        tick();
        check("g_err",   int'(err),   1);
        check("g_valid", int'(valid), 0);
        tick();
        check("g_err_pulse", int'(err), 0);
        do_xfer(8'h5A);                           // proves the block is back in IDLE
        check("g_after_cnt", int'(xcnt), 3);
        check("g_after_data", int'(odata), 8'h5A);

        // Reset released with request already high: never delivered
        #2 rst_n = 1'b0;
        req = 1'b1; ready = 1'b1; data = 8'h77;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("r_no_valid", int'(valid), 0);
            check("r_no_ack",   int'(ack),   0);
        end
        req = 1'b0;
        tick();
        do_xfer(8'h77);
        check("r_cnt1", int'(xcnt), 1);
        check("r_data", int'(odata), 8'h77);

        // 256 transfers wrap the counter back to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            do_xfer(8'(i));
            tick();
        end
        check("w_cnt_wrap", int'(xcnt), 0);

        // Asynchronous reset while a word sits in DELIVER
        ready = 1'b0; data = 8'hC3; req = 1'b1;
        tick(); tick(); tick();
        check("a_valid_pre", int'(valid), 1);
        do_xfer_abort();
        tick();
        rst_n = 1'b1;
        req = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Drops reset mid-cycle and checks outputs clear before any clock edge.
    task automatic do_xfer_abort();
        #2 rst_n = 1'b0;
        #1;
        check("a_ack",   int'(ack),   0);
        check("a_valid", int'(valid), 0);
        check("a_data",  int'(odata), 0);
        check("a_err",   int'(err),   0);
        check("a_cnt",   int'(xcnt),  0);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation ran past its time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_handshake_receiver
